// File: rtl/unpack_float64.sv
// rtl/unpack_float64.sv - binary64 operand unpack into sign/exponent/significand with classification
// Optional build macro: UNPACK_FLOAT64_FTZ_EN (flush subnormal operands to zero, no normaliser)

module unpack_float64 (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [63:0] a,
    input  logic [31:0] float_exception_flag_i,
    output logic [31:0] float_exception_flag_o,
    output logic        float_exception_flag_o_ap_vld,
    output logic        aSign,
    output logic [11:0] aExp,
    output logic [63:0] aSig,
    output logic [2:0]  aClass
);

    // Operand classes as seen by the downstream datapaths
    localparam logic [2:0] CLS_ZERO = 3'd0;
    localparam logic [2:0] CLS_NORM = 3'd1;
    localparam logic [2:0] CLS_SUB  = 3'd2;
    localparam logic [2:0] CLS_INF  = 3'd3;
    localparam logic [2:0] CLS_QNAN = 3'd4;
    localparam logic [2:0] CLS_SNAN = 3'd5;

    // Invalid-operation bit in the softfloat exception word
    localparam logic [31:0] FLAG_INVALID = 32'd16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifndef UNPACK_FLOAT64_FTZ_EN
        S_NORM = 2'd1,
`endif
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_sign;
    logic [11:0] r_exp;
    logic [63:0] r_sig;
    logic [2:0]  r_cls;

`ifndef UNPACK_FLOAT64_FTZ_EN
    // Normaliser working state: sign waits here so the visible outputs hold
    // the previous result until the subnormal finishes.
    logic        r_pend_sign;
    logic [52:0] r_w;
    logic [5:0]  r_cnt;
    logic        w_is_subnormal;
`endif

    logic [10:0] w_exp_field;
    logic [51:0] w_frac;
    logic        w_exp_zero;
    logic        w_exp_max;
    logic        w_frac_zero;
    logic [11:0] w_res_exp;
    logic [63:0] w_res_sig;
    logic [2:0]  w_res_cls;

    assign w_exp_field = a[62:52];
    assign w_frac      = a[51:0];
    assign w_exp_zero  = (w_exp_field == 11'd0);
    assign w_exp_max   = (w_exp_field == 11'h7FF);
    assign w_frac_zero = (w_frac == 52'd0);

`ifndef UNPACK_FLOAT64_FTZ_EN
    assign w_is_subnormal = w_exp_zero && !w_frac_zero;
`endif

    // Single-cycle result for every class that needs no normalisation;
    // subnormals fall into the zero branch, which is the flush result when FTZ is built.
    always_comb begin
        w_res_exp = 12'd0;
        w_res_sig = 64'd0;
        w_res_cls = CLS_ZERO;
        if (w_exp_max) begin
            w_res_exp = 12'h7FF;
            if (w_frac_zero) begin
                w_res_cls = CLS_INF;
            end else begin
                w_res_sig = {2'b00, w_frac, 10'd0};
                w_res_cls = w_frac[51] ? CLS_QNAN : CLS_SNAN;
            end
        end else if (!w_exp_zero) begin
            w_res_exp = {1'b0, w_exp_field} - 12'd1;
            w_res_sig = {2'b01, w_frac, 10'd0};
            w_res_cls = CLS_NORM;
        end
    end

    // Control FSM, result registers and the subnormal leading-zero shifter
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state     <= S_IDLE;
            r_sign      <= 1'b0;
            r_exp       <= 12'd0;
            r_sig       <= 64'd0;
            r_cls       <= CLS_ZERO;
`ifndef UNPACK_FLOAT64_FTZ_EN
            r_pend_sign <= 1'b0;
            r_w         <= 53'd0;
            r_cnt       <= 6'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
`ifdef UNPACK_FLOAT64_FTZ_EN
                        r_sign  <= a[63];
                        r_exp   <= w_res_exp;
                        r_sig   <= w_res_sig;
                        r_cls   <= w_res_cls;
                        r_state <= S_DONE;
`else
                        if (w_is_subnormal) begin
                            r_pend_sign <= a[63];
                            r_w         <= {1'b0, w_frac};
                            r_cnt       <= 6'd0;
                            r_state     <= S_NORM;
                        end else begin
                            r_sign  <= a[63];
                            r_exp   <= w_res_exp;
                            r_sig   <= w_res_sig;
                            r_cls   <= w_res_cls;
                            r_state <= S_DONE;
                        end
`endif
                    end
                end
`ifndef UNPACK_FLOAT64_FTZ_EN
                S_NORM: begin
                    // Coarse byte steps first, then single-bit steps until bit 52 is set
                    if (r_w[52:45] == 8'd0) begin
                        r_w   <= {r_w[44:0], 8'd0};
                        r_cnt <= r_cnt + 6'd8;
                    end else if (!r_w[52]) begin
                        r_w   <= {r_w[51:0], 1'b0};
                        r_cnt <= r_cnt + 6'd1;
                    end else begin
                        r_sign  <= r_pend_sign;
                        r_exp   <= 12'd0 - {6'd0, r_cnt};
                        r_sig   <= {1'b0, r_w, 10'd0};
                        r_cls   <= CLS_SUB;
                        r_state <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ap_done  = (r_state == S_DONE);
    assign ap_ready = ap_done;
    assign ap_idle  = (r_state == S_IDLE) && !ap_start;

    assign aSign  = r_sign;
    assign aExp   = r_exp;
    assign aSig   = r_sig;
    assign aClass = r_cls;

    // Signalling NaN raises invalid in the done cycle only
    always_comb begin
        float_exception_flag_o        = float_exception_flag_i;
        float_exception_flag_o_ap_vld = 1'b0;
        if (ap_done && (r_cls == CLS_SNAN)) begin
            float_exception_flag_o        = float_exception_flag_i | FLAG_INVALID;
            float_exception_flag_o_ap_vld = 1'b1;
        end
    end

endmodule
